rvvi_tx_scheduler: RTL and testbench

- Shares one RVVI transmit port (Ethernet packetizer) between two sources: fresh retired-instruction packets from the core, and replay packets read out of the RVVI active list.
- Pushes fresh packets into the active list in the same cycle they are issued.
- Gives replay absolute priority while the list signals a replay/wait.
- Watches for missing acknowledgements with a timeout counter.
- Sits between the core's RVVI packer, the active list and the packetizer.

---
 rtl/rvvi_pkg.sv | 14 +
 rtl/rvvi_tx_if.sv | 52 +++++
 rtl/rvvi_tx_outreg.sv | 41 ++++
 rtl/rvvi_tx_scheduler.sv | 123 ++++++++++++
 tb/tb_rvvi_tx_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvvi_pkg.sv
// Shared types and default sizing for the RVVI transmit scheduler.
package rvvi_pkg;

    localparam int RVVI_PKT_WIDTH   = 792;
    localparam int RVVI_ACK_TIMEOUT = 4096;
    localparam int RVVI_CNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        ST_NEW,
        ST_REPLAY,
        ST_RESUME
    } txstate_t;

endpackage

// File: rtl/rvvi_tx_if.sv
// Bundle between core packer, active list, packetizer and the tx scheduler.
// Perf counter signals are present only with RVVI_TX_PERF_EN.
interface rvvi_tx_if
    import rvvi_pkg::*;
#(
    parameter int WIDTH = RVVI_PKT_WIDTH
) ();

    logic             NewValid;
    logic [WIDTH-1:0] NewData;
    logic             NewStall;
    logic             AlFull;
    logic             AlEmpty;
    logic             AlWait;
    logic             AlPush;
    logic             ReplayValid;
    logic [WIDTH-1:0] ReplayData;
    logic             ReplayStall;
    logic             AckValid;
    logic             TxValid;
    logic [WIDTH-1:0] TxData;
    logic             TxReplay;
    logic             TxReady;
    logic             ErrClear;
    logic             TimeoutErr;
`ifdef RVVI_TX_PERF_EN
    logic [31:0]      PerfNewCnt;
    logic [31:0]      PerfReplayCnt;
    logic [31:0]      PerfStallCnt;
`endif

    modport master (
        input  NewValid, NewData, AlFull, AlEmpty, AlWait,
        input  ReplayValid, ReplayData, AckValid, TxReady, ErrClear,
        output NewStall, AlPush, ReplayStall,
        output TxValid, TxData, TxReplay, TimeoutErr
`ifdef RVVI_TX_PERF_EN
        , output PerfNewCnt, PerfReplayCnt, PerfStallCnt
`endif
    );

    modport slave (
        output NewValid, NewData, AlFull, AlEmpty, AlWait,
        output ReplayValid, ReplayData, AckValid, TxReady, ErrClear,
        input  NewStall, AlPush, ReplayStall,
        input  TxValid, TxData, TxReplay, TimeoutErr
`ifdef RVVI_TX_PERF_EN
        , input PerfNewCnt, PerfReplayCnt, PerfStallCnt
`endif
    );

endinterface

// File: rtl/rvvi_tx_outreg.sv
// Valid/ready holding register carrying a packet and its replay tag.
module rvvi_tx_outreg #(
    parameter int WIDTH = 792
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             tag_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             tag_o,
    output logic             free_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             tag_q;

    assign free_o  = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign tag_o   = tag_q;

    // Caller only asserts load_i when free_o is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            tag_q   <= tag_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/rvvi_tx_scheduler.sv
// Arbitrates fresh and replay RVVI packets onto one transmit port.
// Define RVVI_TX_PERF_EN to add transfer/stall performance counters.
module rvvi_tx_scheduler
    import rvvi_pkg::*;
#(
    parameter int WIDTH   = RVVI_PKT_WIDTH,
    parameter int TIMEOUT = RVVI_ACK_TIMEOUT,
    parameter int CNTW    = RVVI_CNT_WIDTH
) (
    input logic       clk,
    input logic       reset_n,
    rvvi_tx_if.master bus
);

    localparam logic [CNTW-1:0] TO_MAX = CNTW'(TIMEOUT);

    txstate_t         state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             out_free;
    logic             grant;
    logic             rep_load;
    logic             load;
    logic [WIDTH-1:0] load_data;

    always_comb begin
        state_d         = state_q;
        grant           = 1'b0;
        rep_load        = 1'b0;
        bus.AlPush      = 1'b0;
        bus.NewStall    = bus.NewValid;
        bus.ReplayStall = 1'b1;
        unique case (state_q)
            ST_NEW: begin
                grant = bus.NewValid & out_free & ~bus.AlFull
                      & ~bus.AlWait & ~err_q;
                bus.AlPush   = grant;
                bus.NewStall = bus.NewValid & ~grant;
                if (bus.AlWait) state_d = ST_REPLAY;
            end
            ST_REPLAY: begin
                // Stall is independent of ReplayValid to avoid a comb loop.
                bus.ReplayStall = ~out_free;
                rep_load        = bus.ReplayValid & out_free;
                if (!bus.AlWait) state_d = ST_RESUME;
            end
            ST_RESUME: begin
                if (bus.AlWait)       state_d = ST_REPLAY;
                else if (!bus.TxValid) state_d = ST_NEW;
            end
            default: state_d = ST_NEW;
        endcase
    end

    assign load      = grant | rep_load;
    assign load_data = grant ? bus.NewData : bus.ReplayData;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (bus.ErrClear | bus.AckValid | bus.AlEmpty | (state_q != ST_NEW))
            cnt_d = '0;
        else if (cnt_q != TO_MAX)
            cnt_d = cnt_q + 1'b1;
        if (bus.ErrClear)
            err_d = 1'b0;
        else if (cnt_d == TO_MAX)
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_NEW;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.TimeoutErr = err_q;

    rvvi_tx_outreg #(
        .WIDTH (WIDTH)
    ) u_outreg (
        .clk     (clk),
        .rst_n   (reset_n),
        .load_i  (load),
        .data_i  (load_data),
        .tag_i   (rep_load),
        .ready_i (bus.TxReady),
        .valid_o (bus.TxValid),
        .data_o  (bus.TxData),
        .tag_o   (bus.TxReplay),
        .free_o  (out_free)
    );

`ifdef RVVI_TX_PERF_EN
    logic [31:0] pnew_q, prep_q, pstall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pnew_q   <= '0;
            prep_q   <= '0;
            pstall_q <= '0;
        end else begin
            if (bus.TxValid & bus.TxReady & ~bus.TxReplay)
                pnew_q <= pnew_q + 32'd1;
            if (bus.TxValid & bus.TxReady & bus.TxReplay)
                prep_q <= prep_q + 32'd1;
            if (bus.TxValid & ~bus.TxReady)
                pstall_q <= pstall_q + 32'd1;
        end
    end

    assign bus.PerfNewCnt    = pnew_q;
    assign bus.PerfReplayCnt = prep_q;
    assign bus.PerfStallCnt  = pstall_q;
`endif

endmodule

// File: tb/tb_rvvi_tx_scheduler.sv
// Bench for rvvi_tx_scheduler: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural reference model.
module tb_rvvi_tx_scheduler;
    import rvvi_pkg::*;

    localparam int W  = 792;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    rvvi_tx_if #(.WIDTH(W)) bus ();

    rvvi_tx_scheduler #(
        .WIDTH   (W),
        .TIMEOUT (TO),
        .CNTW    (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 fresh, 1 replaying, 2 resuming
    int          m_mode;
    bit          m_v, m_rep, m_err;
    logic [W-1:0] m_d;
    int          m_cnt;
    int unsigned m_pn, m_pr, m_ps;
    bit          e_push, e_nst, e_rst;

    function automatic logic [W-1:0] rnd_pkt();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < 25; i++) v = {v[W-33:0], 32'($urandom)};
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_v = 0; m_rep = 0; m_err = 0;
        m_d = '0; m_cnt = 0; m_pn = 0; m_pr = 0; m_ps = 0;
    endtask

    task automatic model_comb();
        bit free, grant;
        free  = !m_v || bus.TxReady;
        grant = (m_mode == 0) && bus.NewValid && free && !bus.AlFull
                && !bus.AlWait && !m_err;
        e_push = grant;
        e_nst  = bus.NewValid && !grant;
        e_rst  = !((m_mode == 1) && free);
    endtask

    task automatic model_step();
        int nmode;
        model_comb();
        if (m_v && bus.TxReady) begin
            if (m_rep) m_pr++;
            else       m_pn++;
        end
        if (m_v && !bus.TxReady) m_ps++;
        nmode = m_mode;
        if (m_mode == 0 && bus.AlWait) nmode = 1;
        else if (m_mode == 1 && !bus.AlWait) nmode = 2;
        else if (m_mode == 2) nmode = bus.AlWait ? 1 : (m_v ? 2 : 0);
        if (bus.ErrClear || bus.AckValid || bus.AlEmpty || m_mode != 0)
            m_cnt = 0;
        else if (m_cnt < TO)
            m_cnt++;
        if (bus.ErrClear) m_err = 0;
        else if (m_cnt == TO) m_err = 1;
        if (e_push) begin
            m_v = 1; m_d = bus.NewData; m_rep = 0;
        end else if (!e_rst && bus.ReplayValid) begin
            m_v = 1; m_d = bus.ReplayData; m_rep = 1;
        end else if (bus.TxReady) begin
            m_v = 0;
        end
        m_mode = nmode;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.NewValid = 0; bus.NewData = '0;
        bus.AlFull = 0; bus.AlEmpty = 1; bus.AlWait = 0;
        bus.ReplayValid = 0; bus.ReplayData = '0;
        bus.AckValid = 0; bus.TxReady = 1; bus.ErrClear = 0;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        model_reset();
        #2;
        checks++; if (bus.TxValid !== 1'b0) begin errors++; $display("FAIL reset_txvalid got %b exp 0", bus.TxValid); end
        checks++; if (bus.TxData !== '0) begin errors++; $display("FAIL reset_txdata got %h exp 0", bus.TxData[63:0]); end
        checks++; if (bus.TxReplay !== 1'b0) begin errors++; $display("FAIL reset_txreplay got %b exp 0", bus.TxReplay); end
        checks++; if (bus.TimeoutErr !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.TimeoutErr); end
        checks++; if (bus.ReplayStall !== 1'b1) begin errors++; $display("FAIL reset_rstall got %b exp 1", bus.ReplayStall); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        tick();
    endtask

    task automatic test_fresh();
        logic [W-1:0] d [4];
        idle();
        for (int k = 0; k < 4; k++) begin
            d[k] = rnd_pkt();
            bus.NewValid = 1; bus.NewData = d[k];
            #1;
            checks++; if (bus.AlPush !== 1'b1) begin errors++; $display("FAIL fresh_push k=%0d got %b exp 1", k, bus.AlPush); end
            checks++; if (bus.NewStall !== 1'b0) begin errors++; $display("FAIL fresh_nstall k=%0d got %b exp 0", k, bus.NewStall); end
            tick();
            checks++; if (bus.TxValid !== 1'b1 || bus.TxReplay !== 1'b0) begin errors++; $display("FAIL fresh_tx k=%0d got v=%b r=%b exp v=1 r=0", k, bus.TxValid, bus.TxReplay); end
            checks++; if (bus.TxData !== d[k]) begin errors++; $display("FAIL fresh_data k=%0d got %h exp %h", k, bus.TxData[63:0], d[k][63:0]); end
        end
        bus.NewValid = 0;
        tick();
        checks++; if (bus.TxValid !== 1'b0) begin errors++; $display("FAIL fresh_drain got %b exp 0", bus.TxValid); end
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] p, q;
        idle();
        p = rnd_pkt(); q = rnd_pkt();
        bus.NewValid = 1; bus.NewData = p; bus.TxReady = 0;
        tick();
        bus.NewData = q;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.NewStall !== 1'b1 || bus.AlPush !== 1'b0) begin errors++; $display("FAIL bp_stall k=%0d got ns=%b push=%b exp ns=1 push=0", k, bus.NewStall, bus.AlPush); end
            checks++; if (bus.ReplayStall !== 1'b1) begin errors++; $display("FAIL bp_rstall k=%0d got %b exp 1", k, bus.ReplayStall); end
            tick();
            checks++; if (bus.TxValid !== 1'b1 || bus.TxData !== p) begin errors++; $display("FAIL bp_hold k=%0d got v=%b %h exp v=1 %h", k, bus.TxValid, bus.TxData[63:0], p[63:0]); end
        end
        bus.TxReady = 1;
        #1;
        checks++; if (bus.AlPush !== 1'b1) begin errors++; $display("FAIL bp_release_push got %b exp 1", bus.AlPush); end
        tick();
        checks++; if (bus.TxData !== q) begin errors++; $display("FAIL bp_next_data got %h exp %h", bus.TxData[63:0], q[63:0]); end
        bus.NewValid = 0;
        tick();
    endtask

    task automatic test_replay();
        logic [W-1:0] q;
        logic [W-1:0] r [3];
        idle();
        q = rnd_pkt();
        bus.AlWait = 1; bus.NewValid = 1; bus.NewData = q;
        #1;
        checks++; if (bus.AlPush !== 1'b0 || bus.NewStall !== 1'b1) begin errors++; $display("FAIL rp_enter got push=%b ns=%b exp push=0 ns=1", bus.AlPush, bus.NewStall); end
        tick();
        for (int k = 0; k < 3; k++) begin
            r[k] = rnd_pkt();
            bus.ReplayValid = 1; bus.ReplayData = r[k];
            #1;
            checks++; if (bus.ReplayStall !== 1'b0 || bus.AlPush !== 1'b0 || bus.NewStall !== 1'b1) begin errors++; $display("FAIL rp_ctl k=%0d got rs=%b push=%b ns=%b exp 0 0 1", k, bus.ReplayStall, bus.AlPush, bus.NewStall); end
            tick();
            checks++; if (bus.TxValid !== 1'b1 || bus.TxReplay !== 1'b1 || bus.TxData !== r[k]) begin errors++; $display("FAIL rp_tx k=%0d got v=%b r=%b %h exp v=1 r=1 %h", k, bus.TxValid, bus.TxReplay, bus.TxData[63:0], r[k][63:0]); end
        end
        bus.AlWait = 0; bus.ReplayValid = 0; bus.TxReady = 0;
        #1;
        checks++; if (bus.ReplayStall !== 1'b1) begin errors++; $display("FAIL rp_full_rstall got %b exp 1", bus.ReplayStall); end
        tick();
        #1;
        checks++; if (bus.AlPush !== 1'b0 || bus.NewStall !== 1'b1) begin errors++; $display("FAIL rs_hold got push=%b ns=%b exp 0 1", bus.AlPush, bus.NewStall); end
        tick();
        checks++; if (bus.TxValid !== 1'b1 || bus.TxData !== r[2]) begin errors++; $display("FAIL rs_last got v=%b %h exp v=1 %h", bus.TxValid, bus.TxData[63:0], r[2][63:0]); end
        bus.TxReady = 1;
        #1;
        checks++; if (bus.AlPush !== 1'b0) begin errors++; $display("FAIL rs_drain_push got %b exp 0", bus.AlPush); end
        tick();
        checks++; if (bus.TxValid !== 1'b0) begin errors++; $display("FAIL rs_drained got %b exp 0", bus.TxValid); end
        checks++; if (bus.AlPush !== 1'b0) begin errors++; $display("FAIL rs_nogrant got %b exp 0", bus.AlPush); end
        tick();
        checks++; if (bus.AlPush !== 1'b1) begin errors++; $display("FAIL rs_resume_push got %b exp 1", bus.AlPush); end
        tick();
        checks++; if (bus.TxData !== q || bus.TxReplay !== 1'b0) begin errors++; $display("FAIL rs_fresh got r=%b %h exp r=0 %h", bus.TxReplay, bus.TxData[63:0], q[63:0]); end
        bus.NewValid = 0;
        tick();
    endtask

    task automatic test_full();
        logic [W-1:0] p;
        idle();
        p = rnd_pkt();
        bus.AlFull = 1; bus.NewValid = 1; bus.NewData = p;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.AlPush !== 1'b0 || bus.NewStall !== 1'b1) begin errors++; $display("FAIL full_block k=%0d got push=%b ns=%b exp 0 1", k, bus.AlPush, bus.NewStall); end
            tick();
        end
        bus.AlFull = 0;
        #1;
        checks++; if (bus.AlPush !== 1'b1 || bus.NewStall !== 1'b0) begin errors++; $display("FAIL full_release got push=%b ns=%b exp 1 0", bus.AlPush, bus.NewStall); end
        tick();
        checks++; if (bus.TxValid !== 1'b1 || bus.TxData !== p) begin errors++; $display("FAIL full_data got v=%b %h exp v=1 %h", bus.TxValid, bus.TxData[63:0], p[63:0]); end
        bus.NewValid = 0;
        tick();
    endtask

    task automatic test_timeout();
        logic [W-1:0] p;
        idle();
        tick();
        bus.AlEmpty = 0;
        for (int k = 1; k <= TO; k++) begin
            tick();
            checks++; if (bus.TimeoutErr !== (k == TO)) begin errors++; $display("FAIL to_count k=%0d got %b exp %b", k, bus.TimeoutErr, k == TO); end
        end
        p = rnd_pkt();
        bus.NewValid = 1; bus.NewData = p;
        #1;
        checks++; if (bus.AlPush !== 1'b0 || bus.NewStall !== 1'b1) begin errors++; $display("FAIL to_block got push=%b ns=%b exp 0 1", bus.AlPush, bus.NewStall); end
        tick();
        bus.ErrClear = 1;
        #1;
        checks++; if (bus.AlPush !== 1'b0) begin errors++; $display("FAIL to_clr_push got %b exp 0", bus.AlPush); end
        tick();
        checks++; if (bus.TimeoutErr !== 1'b0) begin errors++; $display("FAIL to_cleared got %b exp 0", bus.TimeoutErr); end
        bus.ErrClear = 0;
        #1;
        checks++; if (bus.AlPush !== 1'b1) begin errors++; $display("FAIL to_resume_push got %b exp 1", bus.AlPush); end
        tick();
        checks++; if (bus.TxData !== p) begin errors++; $display("FAIL to_resume_data got %h exp %h", bus.TxData[63:0], p[63:0]); end
        bus.NewValid = 0; bus.AlEmpty = 1;
        tick();
        bus.AlEmpty = 0;
        for (int c = 1; c <= 13; c++) begin
            bus.AckValid = (c == 5);
            tick();
            checks++; if (bus.TimeoutErr !== (c == 13)) begin errors++; $display("FAIL to_ack c=%0d got %b exp %b", c, bus.TimeoutErr, c == 13); end
        end
        bus.AckValid = 0; bus.ErrClear = 1;
        tick();
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        idle();
        bus.TxReady = 0; bus.NewValid = 1; bus.NewData = rnd_pkt();
        tick();
        bus.NewValid = 0;
        checks++; if (bus.TxValid !== 1'b1) begin errors++; $display("FAIL ar_pre got %b exp 1", bus.TxValid); end
        #2;
        reset_n = 0;
        #1;
        checks++; if (bus.TxValid !== 1'b0) begin errors++; $display("FAIL ar_txvalid got %b exp 0", bus.TxValid); end
`ifdef RVVI_TX_PERF_EN
        checks++; if (bus.PerfNewCnt !== 32'd0) begin errors++; $display("FAIL ar_perf got %0d exp 0", bus.PerfNewCnt); end
`endif
        model_reset();
        idle();
        @(posedge clk);
        #1;
        reset_n = 1;
        #1;
        checks++; if (bus.ReplayStall !== 1'b1 || bus.TxData !== '0) begin errors++; $display("FAIL ar_state got rs=%b %h exp rs=1 0", bus.ReplayStall, bus.TxData[63:0]); end
        tick();
    endtask

    task automatic test_random();
        idle();
        for (int n = 0; n < 600; n++) begin
            bus.NewValid    = $urandom_range(0, 3) != 0;
            bus.NewData     = rnd_pkt();
            bus.AlFull      = $urandom_range(0, 7) == 0;
            bus.AlEmpty     = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 11) == 0) bus.AlWait = ~bus.AlWait;
            bus.ReplayValid = $urandom_range(0, 1);
            bus.ReplayData  = rnd_pkt();
            bus.AckValid    = $urandom_range(0, 15) == 0;
            bus.TxReady     = $urandom_range(0, 3) != 0;
            bus.ErrClear    = $urandom_range(0, 31) == 0;
            #1;
            model_comb();
            checks++; if (bus.TxValid !== m_v) begin errors++; $display("FAIL rnd_txvalid n=%0d got %b exp %b", n, bus.TxValid, m_v); end
            checks++; if (bus.TxData !== m_d) begin errors++; $display("FAIL rnd_txdata n=%0d got %h exp %h", n, bus.TxData[63:0], m_d[63:0]); end
            checks++; if (bus.TxReplay !== m_rep) begin errors++; $display("FAIL rnd_txreplay n=%0d got %b exp %b", n, bus.TxReplay, m_rep); end
            checks++; if (bus.NewStall !== e_nst) begin errors++; $display("FAIL rnd_nstall n=%0d got %b exp %b", n, bus.NewStall, e_nst); end
            checks++; if (bus.AlPush !== e_push) begin errors++; $display("FAIL rnd_push n=%0d got %b exp %b", n, bus.AlPush, e_push); end
            checks++; if (bus.ReplayStall !== e_rst) begin errors++; $display("FAIL rnd_rstall n=%0d got %b exp %b", n, bus.ReplayStall, e_rst); end
            checks++; if (bus.TimeoutErr !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got %b exp %b", n, bus.TimeoutErr, m_err); end
`ifdef RVVI_TX_PERF_EN
            checks++; if (bus.PerfNewCnt !== m_pn || bus.PerfReplayCnt !== m_pr || bus.PerfStallCnt !== m_ps) begin errors++; $display("FAIL rnd_perf n=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", n, bus.PerfNewCnt, bus.PerfReplayCnt, bus.PerfStallCnt, m_pn, m_pr, m_ps); end
`endif
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        reset_n = 0;
        idle();
        test_reset();
        test_fresh();
        test_back_pressure();
        test_replay();
        test_full();
        test_timeout();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
